// File: rtl/fft_stage_sequencer.sv
// fft_stage_sequencer
//   Address and control sequencer for an in-place radix-2 DIT FFT held in a
//   single data BRAM. After a start pulse it walks every stage, issuing one
//   butterfly read (A/B operand addresses plus twiddle index) per accepted
//   handshake. It replays each A/B pair to the write port a fixed BF_LATENCY
//   cycles later. Between stages it waits for the last write-back so that no
//   read of stage s+1 can overtake a write of stage s.
//
// Ports
//   clk, rst_n                 rising-edge clock, asynchronous active-low reset
//   i_start                    start pulse, honoured only while idle
//   o_busy, o_done             transform in progress / one-cycle completion
//   o_rd_valid, i_rd_ready     butterfly read handshake
//   o_rd_addr_a, o_rd_addr_b   operand addresses
//   o_tw_addr                  twiddle ROM index
//   o_stage                    current stage index
//   o_wr_en                    write-back strobe
//   o_wr_addr_a, o_wr_addr_b   write-back addresses
module fft_stage_sequencer #(
  parameter int FFT_SIZE    = 1024,
  parameter int BF_LATENCY  = 4,
  // Derived widths; for a power-of-two size these are log2(N) and the bits
  // needed to hold a stage index 0..log2(N)-1. Leave at their defaults.
  parameter int ADDR_WIDTH  = $clog2(FFT_SIZE),
  parameter int STAGE_WIDTH = $clog2(ADDR_WIDTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_start,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_rd_valid,
  input  logic                   i_rd_ready,
  output logic [ADDR_WIDTH-1:0]  o_rd_addr_a,
  output logic [ADDR_WIDTH-1:0]  o_rd_addr_b,
  output logic [ADDR_WIDTH-2:0]  o_tw_addr,
  output logic [STAGE_WIDTH-1:0] o_stage,
  output logic                   o_wr_en,
  output logic [ADDR_WIDTH-1:0]  o_wr_addr_a,
  output logic [ADDR_WIDTH-1:0]  o_wr_addr_b
);

  // Butterfly index k counts 0..N/2-1 within a stage.
  localparam int KW = ADDR_WIDTH - 1;
  localparam int DW = $clog2(BF_LATENCY + 1);

  localparam logic [KW-1:0]          K_LAST = KW'(FFT_SIZE / 2 - 1);
  localparam logic [STAGE_WIDTH-1:0] S_LAST = STAGE_WIDTH'(ADDR_WIDTH - 1);
  localparam logic [DW-1:0]          D_LAST = DW'(BF_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] a;
    logic [ADDR_WIDTH-1:0] b;
    logic [ADDR_WIDTH-2:0] tw;
  } req_t;

  typedef struct packed {
    logic                  valid;
    logic [ADDR_WIDTH-1:0] a;
    logic [ADDR_WIDTH-1:0] b;
  } wb_t;

  state_t                 state_q, state_d;
  logic [STAGE_WIDTH-1:0] stage_q;
  logic [KW-1:0]          k_q;
  logic [DW-1:0]          drain_q;
  req_t                   req_q;
  wb_t                    pipe_q [BF_LATENCY];

  logic xfer, k_last, s_last, d_last;

  assign xfer   = (state_q == RUN) && i_rd_ready;
  assign k_last = (k_q == K_LAST);
  assign s_last = (stage_q == S_LAST);
  assign d_last = (drain_q == D_LAST);

  // half = 2^s, pos = k mod half, grp = k / half.
  // A = grp*2*half + pos, B = A + half, twiddle = pos * N/(2*half).
  function automatic req_t calc_req(input logic [STAGE_WIDTH-1:0] s,
                                    input logic [KW-1:0] k);
    logic [ADDR_WIDTH-1:0] kk, half, pos, grp, tw_full;
    int unsigned           sh;
    req_t                  r;
    sh      = 32'(s);
    kk      = {1'b0, k};
    half    = ADDR_WIDTH'(1) << sh;
    pos     = kk & (half - ADDR_WIDTH'(1));
    grp     = kk >> sh;
    r.a     = (grp << (sh + 1)) | pos;
    r.b     = r.a + half;
    tw_full = pos << (ADDR_WIDTH - 1 - sh);
    r.tw    = tw_full[ADDR_WIDTH-2:0];
    return r;
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_start) state_d = RUN;
      RUN:     if (xfer && k_last) state_d = DRAIN;
      DRAIN:   if (d_last) state_d = s_last ? DONE : RUN;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stage/butterfly counters and the registered read request. The request
  // is only reloaded on entry to RUN or on a non-final transfer, so it holds
  // its last value during stalls, DRAIN, DONE and IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '0;
      k_q     <= '0;
      drain_q <= '0;
      req_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_start) begin
            stage_q <= '0;
            k_q     <= '0;
            req_q   <= calc_req('0, '0);
          end
        end
        RUN: begin
          if (xfer) begin
            k_q     <= k_q + 1'b1;
            drain_q <= '0;
            if (!k_last) req_q <= calc_req(stage_q, k_q + 1'b1);
          end
        end
        DRAIN: begin
          drain_q <= drain_q + 1'b1;
          if (d_last && !s_last) begin
            stage_q <= stage_q + 1'b1;
            k_q     <= '0;
            req_q   <= calc_req(stage_q + 1'b1, '0);
          end
        end
        default: ;
      endcase
    end
  end

  // Fixed-latency write-back delay line; never stalls, so the butterfly
  // datapath behind it must have exactly BF_LATENCY cycles of latency.
  // NOTE: the whole delay line is reset, addresses included, because its
  // last entry drives the write-address outputs directly and those must be
  // zero out of reset, not just the valid bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BF_LATENCY; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= '{valid: xfer, a: req_q.a, b: req_q.b};
      for (int i = 1; i < BF_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign o_busy      = (state_q != IDLE);
  assign o_done      = (state_q == DONE);
  assign o_rd_valid  = (state_q == RUN);
  assign o_rd_addr_a = req_q.a;
  assign o_rd_addr_b = req_q.b;
  assign o_tw_addr   = req_q.tw;
  assign o_stage     = stage_q;
  assign o_wr_en     = pipe_q[BF_LATENCY-1].valid;
  assign o_wr_addr_a = pipe_q[BF_LATENCY-1].a;
  assign o_wr_addr_b = pipe_q[BF_LATENCY-1].b;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// tb_fft_stage_sequencer
//   Three sequencer instances (N=8/lat 2, N=16/lat 3, N=1024/lat 4) on one
//   clock. A reference model lists every butterfly of the transform from
//   nested stage/group/position loops; a negedge monitor compares the
//   presented requests and the write-backs against those queues.
`timescale 1ns/1ps
module tb_fft_stage_sequencer;

  localparam int NI = 3;

  typedef struct { int a; int b; int tw; int s; } rd_exp_t;
  typedef struct { int due; int a; int b; int s; } wr_exp_t;

  int n_pts [NI] = '{8, 16, 1024};
  int lat   [NI] = '{2, 3, 4};

  logic clk = 1'b0;
  logic rst_n;
  logic start [NI];
  logic ready [NI];

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance outputs
  logic       u0_busy, u0_done, u0_rv, u0_we;
  logic [2:0] u0_ra, u0_rb, u0_wa, u0_wb;
  logic [1:0] u0_tw, u0_st;
  logic       u1_busy, u1_done, u1_rv, u1_we;
  logic [3:0] u1_ra, u1_rb, u1_wa, u1_wb;
  logic [2:0] u1_tw;
  logic [1:0] u1_st;
  logic       u2_busy, u2_done, u2_rv, u2_we;
  logic [9:0] u2_ra, u2_rb, u2_wa, u2_wb;
  logic [8:0] u2_tw;
  logic [3:0] u2_st;

  fft_stage_sequencer #(.FFT_SIZE(8), .BF_LATENCY(2)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .i_start(start[0]), .o_busy(u0_busy),
    .o_done(u0_done), .o_rd_valid(u0_rv), .i_rd_ready(ready[0]),
    .o_rd_addr_a(u0_ra), .o_rd_addr_b(u0_rb), .o_tw_addr(u0_tw),
    .o_stage(u0_st), .o_wr_en(u0_we), .o_wr_addr_a(u0_wa), .o_wr_addr_b(u0_wb)
  );

  fft_stage_sequencer #(.FFT_SIZE(16), .BF_LATENCY(3)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .i_start(start[1]), .o_busy(u1_busy),
    .o_done(u1_done), .o_rd_valid(u1_rv), .i_rd_ready(ready[1]),
    .o_rd_addr_a(u1_ra), .o_rd_addr_b(u1_rb), .o_tw_addr(u1_tw),
    .o_stage(u1_st), .o_wr_en(u1_we), .o_wr_addr_a(u1_wa), .o_wr_addr_b(u1_wb)
  );

  fft_stage_sequencer #(.FFT_SIZE(1024), .BF_LATENCY(4)) u_dut1k (
    .clk(clk), .rst_n(rst_n), .i_start(start[2]), .o_busy(u2_busy),
    .o_done(u2_done), .o_rd_valid(u2_rv), .i_rd_ready(ready[2]),
    .o_rd_addr_a(u2_ra), .o_rd_addr_b(u2_rb), .o_tw_addr(u2_tw),
    .o_stage(u2_st), .o_wr_en(u2_we), .o_wr_addr_a(u2_wa), .o_wr_addr_b(u2_wb)
  );

  // Uniform integer view of the three instances
  int   o_ra [NI], o_rb [NI], o_tw [NI], o_st [NI], o_wa [NI], o_wb [NI];
  logic o_busy [NI], o_done [NI], o_rv [NI], o_we [NI];

  always_comb begin
    o_ra[0] = int'(u0_ra); o_rb[0] = int'(u0_rb); o_tw[0] = int'(u0_tw);
    o_st[0] = int'(u0_st); o_wa[0] = int'(u0_wa); o_wb[0] = int'(u0_wb);
    o_busy[0] = u0_busy; o_done[0] = u0_done; o_rv[0] = u0_rv; o_we[0] = u0_we;
    o_ra[1] = int'(u1_ra); o_rb[1] = int'(u1_rb); o_tw[1] = int'(u1_tw);
    o_st[1] = int'(u1_st); o_wa[1] = int'(u1_wa); o_wb[1] = int'(u1_wb);
    o_busy[1] = u1_busy; o_done[1] = u1_done; o_rv[1] = u1_rv; o_we[1] = u1_we;
    o_ra[2] = int'(u2_ra); o_rb[2] = int'(u2_rb); o_tw[2] = int'(u2_tw);
    o_st[2] = int'(u2_st); o_wa[2] = int'(u2_wa); o_wb[2] = int'(u2_wb);
    o_busy[2] = u2_busy; o_done[2] = u2_done; o_rv[2] = u2_rv; o_we[2] = u2_we;
  end

  // Scoreboard state
  rd_exp_t exp_rd   [NI][$];
  wr_exp_t pend     [NI][$];
  int      xfer_log [NI][$];
  int      wr_log   [NI][$];
  int      start_cyc [NI];
  int      n_done    [NI];
  int      n_xfer    [NI];
  int      done_rel  [NI];
  int      last_wa   [NI];
  int      last_wb   [NI];
  int      last_tw   [NI];
  bit      active    [NI];
  bit      done_prev [NI];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: every butterfly of the transform, in issue order.
  task automatic build_model(input int i);
    int n = n_pts[i];
    int s = 0;
    exp_rd[i].delete();
    for (int half = 1; half < n; half *= 2) begin
      for (int g = 0; g < n / (2 * half); g++) begin
        for (int p = 0; p < half; p++) begin
          rd_exp_t e;
          e.a  = g * 2 * half + p;
          e.b  = e.a + half;
          e.tw = p * (n / (2 * half));
          e.s  = s;
          exp_rd[i].push_back(e);
        end
      end
      s++;
    end
  endtask

  task automatic monitor_one(input int i);
    int      rel = cyc - start_cyc[i];
    rd_exp_t e;
    wr_exp_t w;
    if (active[i] && rel == 1) begin
      check("busy_rise", o_busy[i], 1);
      check("first_valid", o_rv[i], 1);
    end
    if (o_rv[i]) begin
      if (exp_rd[i].size() == 0) begin
        check("rd_unexpected", 1, 0);
      end else begin
        // Held or new, the presented request must be the next one owed.
        e = exp_rd[i][0];
        check("rd_addr_a", o_ra[i], e.a);
        check("rd_addr_b", o_rb[i], e.b);
        check("tw_addr", o_tw[i], e.tw);
        check("stage", o_st[i], e.s);
        if (pend[i].size() > 0) check("raw_order", e.s, pend[i][0].s);
        if (ready[i]) begin
          void'(exp_rd[i].pop_front());
          w.due = cyc + lat[i]; w.a = e.a; w.b = e.b; w.s = e.s;
          pend[i].push_back(w);
          xfer_log[i].push_back(rel);
          n_xfer[i]++;
          last_tw[i] = o_tw[i];
        end
      end
    end
    if (o_we[i]) begin
      if (pend[i].size() == 0) begin
        check("wr_unexpected", 1, 0);
      end else begin
        w = pend[i].pop_front();
        check("wr_cycle", cyc, w.due);
        check("wr_addr_a", o_wa[i], w.a);
        check("wr_addr_b", o_wb[i], w.b);
        wr_log[i].push_back(rel);
        last_wa[i] = o_wa[i];
        last_wb[i] = o_wb[i];
      end
    end else if (pend[i].size() > 0 && pend[i][0].due <= cyc) begin
      check("wr_missing", 0, 1);
      void'(pend[i].pop_front());
    end
    if (o_done[i]) begin
      n_done[i]++;
      done_rel[i] = rel;
      check("busy_at_done", o_busy[i], 1);
    end
    if (done_prev[i]) check("busy_after_done", o_busy[i], 0);
    done_prev[i] = o_done[i];
  endtask

  always @(negedge clk) begin
    if (rst_n) for (int i = 0; i < NI; i++) monitor_one(i);
  end

  // Runs one full transform on instance i. Call just after a rising edge.
  task automatic run(input int i, input bit pulses, input bit rand_ready,
                     input int exp_done, input int budget);
    int d0 = n_done[i];
    int x0 = n_xfer[i];
    int t  = 0;
    int rel;
    build_model(i);
    pend[i].delete();
    xfer_log[i].delete();
    wr_log[i].delete();
    start_cyc[i] = cyc;
    active[i]    = 1'b1;
    start[i]     = 1'b1;
    @(posedge clk); #1;
    start[i] = 1'b0;
    while (n_done[i] == d0 && t < budget) begin
      rel      = cyc - start_cyc[i];
      start[i] = pulses && (rel == 3 || rel == 10);
      ready[i] = rand_ready ? ($urandom_range(0, 9) < 6) : 1'b1;
      @(posedge clk); #1;
      t++;
    end
    if (n_done[i] == d0) check("done_timeout", 0, 1);
    start[i] = 1'b0;
    ready[i] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("done_count", n_done[i] - d0, 1);
    if (exp_done >= 0) check("done_cycle", done_rel[i], exp_done);
    check("reads_left", exp_rd[i].size(), 0);
    check("writes_left", pend[i].size(), 0);
    check("xfer_count", n_xfer[i] - x0, (n_pts[i] / 2) * $clog2(n_pts[i]));
    active[i] = 1'b0;
  endtask

  // Start instance 0, assert reset mid stage 1 with a write in flight.
  task automatic reset_mid_run();
    int d0 = n_done[0];
    build_model(0);
    pend[0].delete();
    start_cyc[0] = cyc;
    active[0]    = 1'b1;
    start[0]     = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    // Relative cycle 9: stage-1 transfer from cycle 7 is being written back.
    check("pre_reset_wr_en", o_we[0], 1);
    check("pre_reset_stage", o_st[0], 1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_wr_en", o_we[0], 0);
    check("rst_rd_valid", o_rv[0], 0);
    check("rst_busy", o_busy[0], 0);
    check("rst_done", o_done[0], 0);
    exp_rd[0].delete();
    pend[0].delete();
    active[0]    = 1'b0;
    done_prev[0] = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("no_done_after_abort", n_done[0] - d0, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < NI; i++) begin
      start[i] = 1'b0; ready[i] = 1'b1;
      start_cyc[i] = 0; n_done[i] = 0; n_xfer[i] = 0; done_rel[i] = -1;
      last_wa[i] = -1; last_wb[i] = -1; last_tw[i] = -1;
      active[i] = 1'b0; done_prev[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #2;
    for (int i = 0; i < NI; i++) begin
      check("reset_rd_valid", o_rv[i], 0);
      check("reset_busy", o_busy[i], 0);
      check("reset_done", o_done[i], 0);
      check("reset_wr_en", o_we[i], 0);
      check("reset_rd_addr_a", o_ra[i], 0);
      check("reset_rd_addr_b", o_rb[i], 0);
      check("reset_tw_addr", o_tw[i], 0);
      check("reset_stage", o_st[i], 0);
      check("reset_wr_addr_a", o_wa[i], 0);
      check("reset_wr_addr_b", o_wb[i], 0);
    end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // N=8, unstalled, with ignored start pulses at cycles 3 and 10
    run(0, 1'b1, 1'b0, 19, 100);
    if (xfer_log[0].size() >= 5 && wr_log[0].size() >= 4) begin
      check("last_stage0_xfer_cycle", xfer_log[0][3], 4);
      check("last_stage0_wr_cycle", wr_log[0][3], 6);
      check("first_stage1_xfer_cycle", xfer_log[0][4], 7);
    end else begin
      check("boundary_log_size", xfer_log[0].size(), 12);
    end

    // Abort mid stage 1, then a clean rerun
    reset_mid_run();
    run(0, 1'b0, 1'b0, 19, 100);

    // N=16 with random backpressure
    run(1, 1'b0, 1'b1, -1, 2000);
    run(1, 1'b0, 1'b1, -1, 2000);

    // N=1024, ready held high
    run(2, 1'b0, 1'b0, 5161, 6000);
    check("n1k_last_wr_a", last_wa[2], 511);
    check("n1k_last_wr_b", last_wb[2], 1023);
    check("n1k_last_tw", last_tw[2], 511);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
